// File: rtl/pts_bit_streamer_pkg.sv
// pts_bit_streamer_pkg: shared FSM state type and default word width for the bit streamer
package pts_pkg;
    typedef enum logic [1:0] {IDLE, SHIFT, PARITY} state_t;
    localparam int DEF_NUM_BITS = 8;
endpackage

// File: rtl/pts_bit_streamer_if.sv
// pts_bit_streamer_if: load handshake + serial output bundle
//   master (upstream/consumer side): drives load_data, load_valid, shift_enable
//   slave  (streamer side):          drives load_ready, serial_out, busy, done
interface pts_bit_streamer_if import pts_pkg::*; #(parameter int NUM_BITS = DEF_NUM_BITS);
    logic [NUM_BITS-1:0] load_data;
    logic                load_valid;
    logic                load_ready;
    logic                shift_enable;
    logic                serial_out;
    logic                busy;
    logic                done;
    modport master (output load_data, load_valid, shift_enable, input load_ready, serial_out, busy, done);
    modport slave  (input load_data, load_valid, shift_enable, output load_ready, serial_out, busy, done);
endinterface

// File: rtl/pts_bit_counter.sv
// pts_bit_counter: bit-position counter, wraps to 0 after rollover_val
//   clk, n_rst (async active-low), clear (priority), count_enable, rollover_val
//   count, at_last (count == rollover_val)
module pts_bit_counter #(parameter int WIDTH = 4) (
    input  logic             clk,
    input  logic             n_rst,
    input  logic             clear,
    input  logic             count_enable,
    input  logic [WIDTH-1:0] rollover_val,
    output logic [WIDTH-1:0] count,
    output logic             at_last
);
    assign at_last = count == rollover_val;
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) count <= '0;
        else if (clear) count <= '0;
        else if (count_enable) count <= at_last ? '0 : count + 1'b1;
    end
endmodule

// File: rtl/pts_bit_streamer.sv
// pts_bit_streamer: parallel-to-serial streamer, one bit per enabled clock, back-to-back words
//   clk, n_rst (async active-low), bus (pts_bit_streamer_if.slave)
//   optional even-parity bit after each word when PTS_PARITY_EN is defined
module pts_bit_streamer import pts_pkg::*; #(
    parameter int NUM_BITS  = DEF_NUM_BITS,
    parameter int MSB_FIRST = 1
) (
    input logic                 clk,
    input logic                 n_rst,
    pts_bit_streamer_if.slave   bus
);
    localparam int CW = $clog2(NUM_BITS + 1);
    state_t              state_q, state_d;
    logic [NUM_BITS-1:0] sr_q;
    logic [CW-1:0]       cnt;
    logic                at_last, final_c, accept, head, done_q;
`ifdef PTS_PARITY_EN
    logic                par_q;
    assign final_c = state_q == PARITY;
`else
    assign final_c = state_q == SHIFT && at_last;
`endif
    // A new word may only be taken when the last bit-time is actually being consumed.
    assign bus.load_ready = state_q == IDLE || (final_c && bus.shift_enable);
    assign accept         = bus.load_valid && bus.load_ready;
    assign head           = MSB_FIRST != 0 ? sr_q[NUM_BITS-1] : sr_q[0];
    assign bus.busy       = state_q != IDLE;
    assign bus.done       = done_q;
`ifdef PTS_PARITY_EN
    assign bus.serial_out = state_q == PARITY ? par_q : state_q == SHIFT && head;
`else
    assign bus.serial_out = state_q == SHIFT && head;
`endif
    pts_bit_counter #(.WIDTH(CW)) u_cnt (
        .clk          (clk),
        .n_rst        (n_rst),
        .clear        (accept),
        .count_enable (state_q == SHIFT && bus.shift_enable),
        .rollover_val (CW'(NUM_BITS - 1)),
        .count        (cnt),
        .at_last      (at_last)
    );
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    state_d = accept ? SHIFT : IDLE;
`ifdef PTS_PARITY_EN
            SHIFT:   state_d = bus.shift_enable && at_last ? PARITY : SHIFT;
            PARITY:  state_d = bus.shift_enable ? (accept ? SHIFT : IDLE) : PARITY;
`else
            SHIFT:   state_d = bus.shift_enable && at_last ? (accept ? SHIFT : IDLE) : SHIFT;
`endif
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q <= IDLE;
            sr_q    <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            done_q  <= final_c && bus.shift_enable;
            if (accept) sr_q <= bus.load_data;
            else if (state_q == SHIFT && bus.shift_enable)
                sr_q <= MSB_FIRST != 0 ? {sr_q[NUM_BITS-2:0], 1'b0} : {1'b0, sr_q[NUM_BITS-1:1]};
        end
    end
`ifdef PTS_PARITY_EN
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) par_q <= 1'b0;
        else if (accept) par_q <= ^bus.load_data;
    end
`else
    logic unused_cnt;
    assign unused_cnt = ^cnt;
`endif
endmodule
